// File: rtl/logic_gate_pipe_pkg.sv
// +-----------------------------------------------------------------------------+
// | Module      : logic_gate_pkg                                                 |
// | Description : Shared types and helpers for the registered gate pipeline:    |
// |               gate-op encoding, reduction-flag bundle, per-lane gate eval.   |
// | Revision    : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
`default_nettype none

package logic_gate_pkg;

    localparam int OP_W    = 3;
    localparam int FLAGS_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'd0,
        OP_NAND  = 3'd1,
        OP_OR    = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOTA  = 3'd6,
        OP_PASSA = 3'd7
    } gate_op_e;

    // Packed so it can ride directly in a pipeline payload: {all1, all0, par}.
    typedef struct packed {
        logic all1;
        logic all0;
        logic par;
    } flags_t;

    // Single-lane gate evaluation. The datapath applies it across every bit
    // lane, which keeps the helper independent of the operand width.
    function automatic logic gate_eval(gate_op_e op, logic a, logic b);
        logic y;
        case (op)
            OP_AND:   y = a & b;
            OP_NAND:  y = ~(a & b);
            OP_OR:    y = a | b;
            OP_NOR:   y = ~(a | b);
            OP_XOR:   y = a ^ b;
            OP_XNOR:  y = ~(a ^ b);
            OP_NOTA:  y = ~a;
            default:  y = a;
        endcase
        return y;
    endfunction

    // Identity element for the flag fold: an empty vector is all-ones,
    // all-zeros and even parity until the first lane is folded in.
    function automatic flags_t flags_seed();
        flags_t f;
        f.all1 = 1'b1;
        f.all0 = 1'b1;
        f.par  = 1'b0;
        return f;
    endfunction

    // Fold one result lane into the running reduction flags.
    function automatic flags_t reduce_flags(flags_t acc, logic y);
        flags_t f;
        f.all1 = acc.all1 & y;
        f.all0 = acc.all0 & ~y;
        f.par  = acc.par ^ y;
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/logic_gate_pipe_stage.sv
// +-----------------------------------------------------------------------------+
// | Module      : pipe_stage                                                     |
// | Description : Generic valid/ready register slice. Loads when empty or when  |
// |               its current beat is being taken downstream, so a lone beat    |
// |               always moves forward into an empty slot.                      |
// | Revision    : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
`default_nettype none

module pipe_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              load;

    // Next-state: accept a new beat (or a bubble) whenever the slot frees up;
    // payload only changes on a real handshake so idle inputs never leak in.
    always_comb begin
        load    = ~valid_q | out_ready;
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    // Slot register; reset drops any held beat immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = load;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

`default_nettype wire

// File: rtl/logic_gate_pipe.sv
// +-----------------------------------------------------------------------------+
// | Module      : logic_gate_pipe                                                |
// | Description : Two-stage valid/ready pipeline applying a runtime-selected    |
// |               bitwise gate to WIDTH-bit operands, with registered reduction |
// |               flags and a saturating completed-transfer counter.            |
// | Revision    : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
`default_nettype none

module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_all1,
    output logic             out_all0,
    output logic             out_par,
    output logic [CNT_W-1:0] xfer_cnt,
    input  logic             cnt_clr
);

    // Stage-1 payload {op, b, a}; stage-2 payload {flags, y}.
    localparam int S1_W = OP_W + 2 * WIDTH;
    localparam int S2_W = FLAGS_W + WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [S1_W-1:0]  s1_in_data;
    logic [S1_W-1:0]  s1_data;
    logic             s1_valid;
    logic             s2_ready;
    logic [S2_W-1:0]  s2_in_data;
    logic [S2_W-1:0]  s2_data;

    gate_op_e         eval_op;
    logic [WIDTH-1:0] eval_a;
    logic [WIDTH-1:0] eval_b;
    logic [WIDTH-1:0] eval_y;
    flags_t           eval_flags;

    logic [CNT_W-1:0] xfer_cnt_q;
    logic [CNT_W-1:0] xfer_cnt_d;

    assign s1_in_data = {in_op, in_b, in_a};

    pipe_stage #(
        .DATA_W (S1_W)
    ) u_stage1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in_data),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_data)
    );

    // Stage-2 evaluation: apply the captured op lane by lane and fold the
    // flags from the very result that gets registered, so they always agree.
    always_comb begin
        eval_a     = s1_data[WIDTH-1:0];
        eval_b     = s1_data[2*WIDTH-1:WIDTH];
        eval_op    = gate_op_e'(s1_data[S1_W-1 -: OP_W]);
        eval_y     = '0;
        eval_flags = flags_seed();
        for (int i = 0; i < WIDTH; i++) begin
            eval_y[i]  = gate_eval(eval_op, eval_a[i], eval_b[i]);
            eval_flags = reduce_flags(eval_flags, eval_y[i]);
        end
    end

    assign s2_in_data = {eval_flags, eval_y};

    pipe_stage #(
        .DATA_W (S2_W)
    ) u_stage2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

    assign out_y    = s2_data[WIDTH-1:0];
    assign out_all1 = s2_data[WIDTH+2];
    assign out_all0 = s2_data[WIDTH+1];
    assign out_par  = s2_data[WIDTH];

    // Counter next-state: clear wins over a same-cycle transfer; otherwise
    // count each output handshake and stick at the maximum value.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (cnt_clr) begin
            xfer_cnt_d = '0;
        end else if (out_valid && out_ready && (xfer_cnt_q != CNT_MAX)) begin
            xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
        end
    end

    // Completed-transfer counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;

endmodule

`default_nettype wire
